fir_stream_sequencer: RTL and testbench
=======================================

Name: fir_stream_sequencer

Overview:
Sequences the shared low-pass FIR IP (14-bit sink, 18-bit source, Avalon-ST valid plus 2-bit error) in the PIG demodulation chain. It paces ADC samples into the FIR at a programmable rate and holds the FIR in reset during start-up and recovery. It discards the FIR's warm-up outputs and registers clean results for downstream. It also watches source_err and output starvation, and restarts the filter automatically when either occurs.

Parameters:
DATA_W, 14, sink sample width
OUT_W, 18, source result width
DIV_W, 16, width of rate divider
RST_CYCLES, 16, cycles o_fir_rstn is held low per restart
WARMUP_OUTS, 64, FIR outputs discarded after each restart
TIMEOUT, 4096, max cycles between source valids while strobing, before a fault

Ports:
i_clk  in  1  system clock
i_rstn  in  1  synchronous active-low reset
i_enable  in  1  1 = run the sequencer; 0 = return to IDLE
i_rate_div  in  DIV_W  one sink strobe every i_rate_div clocks; 0 or 1 means every clock
i_adc_data  in  DATA_W  signed ADC sample
o_fir_rstn  out  1  FIR reset, active low
o_sink_valid  out  1  FIR sink_valid strobe
o_sink_data  out  DATA_W  FIR data_in
i_source_valid  in  1  FIR data_valid
i_source_data  in  OUT_W  FIR data_out
i_source_err  in  2  FIR source_err
o_data  out  OUT_W  registered filtered result
o_data_valid  out  1  one-cycle strobe per accepted result
o_state  out  3  IDLE=0, FIR_RST=1, WARMUP=2, RUN=3, FAULT=4
o_err_cnt  out  8  fault count, saturates at 255

Behaviour:
- Reset (i_rstn=0 at a clock edge): state IDLE; o_fir_rstn=0; o_sink_valid=0; o_sink_data=0; o_data=0; o_data_valid=0; o_err_cnt=0. Reset overrides every other input.
- Every output is registered. Reset mid-operation aborts immediately with no flush.
- IDLE: o_fir_rstn=0 and no strobes.
  - i_enable=1 -> FIR_RST.
- FIR_RST: o_fir_rstn=0 for exactly RST_CYCLES clocks, then -> WARMUP.
  - Entering FIR_RST clears the divider counter, warm-up counter and watchdog.
- WARMUP and RUN:
  - o_fir_rstn=1.
  - The divider counts 0..D-1, where D=max(i_rate_div,1). When the count equals D-1, the counter wraps to 0 and o_sink_valid=1 for one cycle. On that same edge o_sink_data <= i_adc_data.
  - The first strobe occurs D cycles after entering WARMUP.
  - A change to i_rate_div takes effect at the next wrap.
- WARMUP: each i_source_valid with i_source_err=0 increments the warm-up counter and is not forwarded. After WARMUP_OUTS such outputs -> RUN. The output that completes the count is itself discarded.
- RUN: on i_source_valid=1 with i_source_err=0, o_data <= i_source_data and o_data_valid=1 on the next cycle (latency 1). o_data holds its value between strobes.
- Watchdog (WARMUP and RUN only):
  - Counts clocks since the last i_source_valid, or since WARMUP entry.
  - Reaching TIMEOUT -> FAULT.
- Any i_source_err != 0 in WARMUP or RUN -> FAULT. This applies whether or not i_source_valid is set. That cycle's data is never forwarded.
- FAULT: lasts 1 cycle. o_err_cnt increments, saturating at 255. o_sink_valid=0, o_fir_rstn=0. Then -> FIR_RST.
- i_enable=0 in any state -> IDLE on the next edge. o_fir_rstn=0, strobes stop, o_data_valid=0. o_data and o_err_cnt are retained.
- Precedence on the same edge: i_rstn > i_enable=0 > error/timeout > normal transition.
- An error and a valid arriving together count as an error.
- The last warm-up output and an error arriving together go to FAULT.

Test Plan:
- Reset release with i_enable=1, i_rate_div=10 -> o_fir_rstn low 16 cycles, then the first o_sink_valid 10 cycles later, then a strobe every 10 clocks. o_sink_data equals i_adc_data sampled at the strobe edge.
- i_rate_div=0, then 1, then 3 mid-run -> a strobe every clock, then every clock, then every 3 clocks starting after the next wrap.
- Model FIR returns 70 valids during WARMUP -> first 64 are dropped, state=3, exactly 6 o_data_valid pulses, each 1 cycle after its i_source_valid with matching data.
- i_source_err=2'b01 for one cycle in RUN -> state 4 then 1, o_err_cnt=1, o_fir_rstn low 16 cycles, warm-up repeats, nothing forwarded on the error cycle.
- Source stalls for 4096 cycles in RUN -> FAULT, o_err_cnt increments; 256 forced faults -> o_err_cnt stays at 255.
- i_enable dropped during WARMUP, then i_rstn pulsed low during RUN -> IDLE with o_fir_rstn=0 and no strobes; reset clears o_data and o_err_cnt to 0.

Source files
------------

// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: paces ADC samples into a shared FIR, hides its
// warm-up transient and restarts it on source errors or output starvation.
module fir_stream_sequencer #(
   parameter int DATA_W      = 14,
   parameter int OUT_W       = 18,
   parameter int DIV_W       = 16,
   parameter int RST_CYCLES  = 16,
   parameter int WARMUP_OUTS = 64,
   parameter int TIMEOUT     = 4096
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_enable,
   input  logic [DIV_W-1:0]  i_rate_div,
   input  logic [DATA_W-1:0] i_adc_data,
   output logic              o_fir_rstn,
   output logic              o_sink_valid,
   output logic [DATA_W-1:0] o_sink_data,
   input  logic              i_source_valid,
   input  logic [OUT_W-1:0]  i_source_data,
   input  logic [1:0]        i_source_err,
   output logic [OUT_W-1:0]  o_data,
   output logic              o_data_valid,
   output logic [2:0]        o_state,
   output logic [7:0]        o_err_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FIR_RST = 3'd1,
      WARMUP  = 3'd2,
      RUN     = 3'd3,
      FAULT   = 3'd4
   } state_t;

   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int WW = $clog2(WARMUP_OUTS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP_OUTS - 1);
   localparam logic [TW-1:0]    WDOG_LAST = TW'(TIMEOUT - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

   state_t            state, state_nx;
   logic [RW-1:0]     rst_cnt, rst_cnt_nx;
   logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
   logic [DIV_W-1:0]  div_lat, div_lat_nx;
   logic [WW-1:0]     warm_cnt, warm_nx;
   logic [TW-1:0]     wdog, wdog_nx;
   logic              fir_rstn_nx;
   logic              sink_valid_nx;
   logic [DATA_W-1:0] sink_data_nx;
   logic [OUT_W-1:0]  data_nx;
   logic              data_valid_nx;
   logic [7:0]        err_cnt_nx;

   logic              err;
   logic              wrap;
   logic              timeout;
   logic              active;
   logic [DIV_W-1:0]  rate_eff;

   always_comb begin
      state_nx      = state;
      rst_cnt_nx    = '0;
      div_cnt_nx    = '0;
      div_lat_nx    = div_lat;
      warm_nx       = '0;
      wdog_nx       = '0;
      sink_valid_nx = 1'b0;
      sink_data_nx  = o_sink_data;
      data_nx       = o_data;
      data_valid_nx = 1'b0;
      err_cnt_nx    = o_err_cnt;

      err      = |i_source_err;
      rate_eff = (i_rate_div == '0) ? DIV_ONE : i_rate_div;
      wrap     = (div_cnt == div_lat - DIV_ONE);
      timeout  = !i_source_valid && (wdog == WDOG_LAST);

      unique case (state)
         IDLE: begin
            if (i_enable) state_nx = FIR_RST;
         end
         FIR_RST: begin
            rst_cnt_nx = rst_cnt + RW'(1);
            // period for the first WARMUP strobe is the rate seen at entry
            div_lat_nx = rate_eff;
            if (rst_cnt == RST_LAST) state_nx = WARMUP;
         end
         WARMUP, RUN: begin
            warm_nx    = warm_cnt;
            div_cnt_nx = wrap ? '0 : div_cnt + DIV_ONE;
            wdog_nx    = i_source_valid ? '0 : wdog + TW'(1);
            if (wrap) begin
               sink_valid_nx = 1'b1;
               sink_data_nx  = i_adc_data;
               div_lat_nx    = rate_eff;
            end
            if (err || timeout) begin
               state_nx = FAULT;
            end else if (i_source_valid) begin
               if (state == WARMUP) begin
                  if (warm_cnt == WARM_LAST) state_nx = RUN;
                  else warm_nx = warm_cnt + WW'(1);
               end else begin
                  data_nx       = i_source_data;
                  data_valid_nx = 1'b1;
               end
            end
         end
         FAULT: begin
            state_nx = FIR_RST;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      if (state_nx == FAULT) begin
         err_cnt_nx = (o_err_cnt == 8'hff) ? o_err_cnt : o_err_cnt + 8'd1;
      end

      if (!i_enable) begin
         state_nx      = IDLE;
         data_valid_nx = 1'b0;
         err_cnt_nx    = o_err_cnt;
      end

      active      = (state_nx == WARMUP) || (state_nx == RUN);
      fir_rstn_nx = active;
      if (!active) sink_valid_nx = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state        <= IDLE;
         rst_cnt      <= '0;
         div_cnt      <= '0;
         div_lat      <= DIV_ONE;
         warm_cnt     <= '0;
         wdog         <= '0;
         o_fir_rstn   <= 1'b0;
         o_sink_valid <= 1'b0;
         o_sink_data  <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_err_cnt    <= '0;
      end else begin
         state        <= state_nx;
         rst_cnt      <= rst_cnt_nx;
         div_cnt      <= div_cnt_nx;
         div_lat      <= div_lat_nx;
         warm_cnt     <= warm_nx;
         wdog         <= wdog_nx;
         o_fir_rstn   <= fir_rstn_nx;
         o_sink_valid <= sink_valid_nx;
         o_sink_data  <= sink_data_nx;
         o_data       <= data_nx;
         o_data_valid <= data_valid_nx;
         o_err_cnt    <= err_cnt_nx;
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer: randomized scenario bench for the FIR sequencer,
// predicting strobes, forwarding and faults from timing rules.
module tb_fir_stream_sequencer;

   localparam int DATA_W      = 14;
   localparam int OUT_W       = 18;
   localparam int DIV_W       = 16;
   localparam int RST_CYCLES  = 16;
   localparam int WARMUP_OUTS = 64;
   localparam int TIMEOUT     = 4096;

   logic              clk = 1'b0;
   logic              rstn;
   logic              enable;
   logic [DIV_W-1:0]  rate_div;
   logic [DATA_W-1:0] adc;
   logic              fir_rstn;
   logic              sink_valid;
   logic [DATA_W-1:0] sink_data;
   logic              src_valid;
   logic [OUT_W-1:0]  src_data;
   logic [1:0]        src_err;
   logic [OUT_W-1:0]  data;
   logic              data_valid;
   logic [2:0]        state;
   logic [7:0]        err_cnt;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int next_strobe = 0;
   int faults = 0;
   logic [OUT_W-1:0] last_data = '0;

   always #5 clk = ~clk;

   fir_stream_sequencer #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .DIV_W(DIV_W),
      .RST_CYCLES(RST_CYCLES), .WARMUP_OUTS(WARMUP_OUTS),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk(clk),
      .i_rstn(rstn),
      .i_enable(enable),
      .i_rate_div(rate_div),
      .i_adc_data(adc),
      .o_fir_rstn(fir_rstn),
      .o_sink_valid(sink_valid),
      .o_sink_data(sink_data),
      .i_source_valid(src_valid),
      .i_source_data(src_data),
      .i_source_err(src_err),
      .o_data(data),
      .o_data_valid(data_valid),
      .o_state(state),
      .o_err_cnt(err_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      enable = 1'b1;
      rate_div = 16'd3;
      src_valid = 1'b1;
      src_err = 2'b10;
      for (int i = 0; i < 4; i++) begin
         adc = DATA_W'($urandom);
         src_data = OUT_W'($urandom);
         step();
      end
      tests++;
      if (state !== 3'd0) begin
         fails++;
         $display("FAIL reset_state got %0d want 0", state);
      end
      tests++;
      if ({fir_rstn, sink_valid, data_valid} !== 3'b000) begin
         fails++;
         $display("FAIL reset_strobes got %b want 000",
                  {fir_rstn, sink_valid, data_valid});
      end
      tests++;
      if (sink_data !== '0 || data !== '0 || err_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_regs got sd=%0h d=%0h ec=%0d want 0",
                  sink_data, data, err_cnt);
      end
   endtask

   // 1 IDLE cycle, 16 FIR_RST cycles, WARMUP from edge 17, strobes every 10
   task automatic test_pacing();
      logic [DATA_W-1:0] drv;
      logic [2:0] st;
      logic fr, sv;
      src_valid = 1'b0;
      src_err = 2'b00;
      rate_div = 16'd10;
      enable = 1'b1;
      rstn = 1'b1;
      for (int n = 1; n <= 80; n++) begin
         drv = DATA_W'($urandom);
         adc = drv;
         step();
         st = (n <= RST_CYCLES) ? 3'd1 : 3'd2;
         fr = (n >= RST_CYCLES + 1);
         sv = (n > RST_CYCLES + 1) && ((n - RST_CYCLES - 1) % 10 == 0);
         tests++;
         if (state !== st || fir_rstn !== fr || sink_valid !== sv) begin
            fails++;
            $display("FAIL pacing n=%0d got st=%0d fr=%b sv=%b want %0d %b %b",
                     n, state, fir_rstn, sink_valid, st, fr, sv);
         end
         if (sv) begin
            tests++;
            if (sink_data !== drv) begin
               fails++;
               $display("FAIL pacing_data n=%0d got %0h want %0h",
                        n, sink_data, drv);
            end
         end
      end
      next_strobe = cyc + 7;
   endtask

   // each strobe schedules the next max(rate,1) clocks later
   task automatic test_rate_change();
      logic [DATA_W-1:0] drv;
      logic [DIV_W-1:0] r;
      logic sv;
      int d;
      for (int i = 0; i < 75; i++) begin
         r = (i < 20) ? 16'd0 : (i < 40) ? 16'd1 : 16'd3;
         rate_div = r;
         drv = DATA_W'($urandom);
         adc = drv;
         step();
         sv = (cyc == next_strobe);
         if (sv) begin
            d = (r == 0) ? 1 : int'(r);
            next_strobe = cyc + d;
         end
         tests++;
         if (sink_valid !== sv) begin
            fails++;
            $display("FAIL rate i=%0d got sv=%b want %b", i, sink_valid, sv);
         end else if (sv && sink_data !== drv) begin
            fails++;
            $display("FAIL rate_data i=%0d got %0h want %0h",
                     i, sink_data, drv);
         end
      end
   endtask

   task automatic test_warmup();
      logic [OUT_W-1:0] drv;
      logic v, dv;
      logic [2:0] st;
      int sent = 0;
      int pulses = 0;
      rate_div = 16'd1;
      for (int i = 0; i < 400 && sent < 70; i++) begin
         v = ($urandom_range(0, 1) == 1);
         drv = OUT_W'($urandom);
         src_valid = v;
         src_data = drv;
         step();
         dv = v && (sent >= WARMUP_OUTS);
         if (v) sent++;
         if (dv) last_data = drv;
         st = (sent >= WARMUP_OUTS) ? 3'd3 : 3'd2;
         if (data_valid) pulses++;
         tests++;
         if (data_valid !== dv || data !== last_data || state !== st) begin
            fails++;
            $display("FAIL warmup i=%0d got dv=%b d=%0h st=%0d want %b %0h %0d",
                     i, data_valid, data, state, dv, last_data, st);
         end
      end
      src_valid = 1'b0;
      step();
      tests++;
      if (pulses !== 6 || data_valid !== 1'b0) begin
         fails++;
         $display("FAIL warmup_pulses got %0d want 6", pulses);
      end
   endtask

   task automatic test_error();
      src_valid = 1'b1;
      src_data = OUT_W'($urandom);
      src_err = 2'b01;
      step();
      src_valid = 1'b0;
      src_err = 2'b00;
      tests++;
      if (state !== 3'd4 || data_valid !== 1'b0 || data !== last_data ||
          fir_rstn !== 1'b0 || sink_valid !== 1'b0) begin
         fails++;
         $display("FAIL err_fault got st=%0d dv=%b d=%0h fr=%b want 4 0 %0h 0",
                  state, data_valid, data, fir_rstn, last_data);
      end
      for (int i = 1; i <= RST_CYCLES; i++) begin
         step();
         tests++;
         if (state !== 3'd1 || fir_rstn !== 1'b0) begin
            fails++;
            $display("FAIL err_rst i=%0d got st=%0d fr=%b want 1 0",
                     i, state, fir_rstn);
         end
      end
      tests++;
      if (err_cnt !== 8'd1) begin
         fails++;
         $display("FAIL err_cnt got %0d want 1", err_cnt);
      end
      step();
      tests++;
      if (state !== 3'd2 || fir_rstn !== 1'b1) begin
         fails++;
         $display("FAIL err_rewarm got st=%0d fr=%b want 2 1", state, fir_rstn);
      end
      for (int i = 0; i < WARMUP_OUTS; i++) begin
         src_valid = 1'b1;
         src_data = OUT_W'($urandom);
         step();
         tests++;
         if (data_valid !== 1'b0) begin
            fails++;
            $display("FAIL err_rewarm_fwd i=%0d got dv=1 want 0", i);
         end
      end
      src_valid = 1'b0;
      tests++;
      if (state !== 3'd3) begin
         fails++;
         $display("FAIL err_run got st=%0d want 3", state);
      end
      faults = 1;
   endtask

   task automatic test_timeout();
      bit early = 1'b0;
      for (int i = 1; i < TIMEOUT; i++) begin
         step();
         if (state !== 3'd3) early = 1'b1;
      end
      tests++;
      if (early) begin
         fails++;
         $display("FAIL timeout_early got fault want run");
      end
      step();
      tests++;
      if (state !== 3'd4) begin
         fails++;
         $display("FAIL timeout got st=%0d want 4", state);
      end
      step();
      faults++;
      tests++;
      if (err_cnt !== 8'd2 || state !== 3'd1) begin
         fails++;
         $display("FAIL timeout_cnt got ec=%0d st=%0d want 2 1", err_cnt, state);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] exp;
      for (int f = 0; f < 256; f++) begin
         for (int k = 0; k < 64 && state !== 3'd2; k++) step();
         tests++;
         if (state !== 3'd2) begin
            fails++;
            $display("FAIL sat_wait got st=%0d want 2", state);
            break;
         end
         src_err = 2'($urandom_range(1, 3));
         step();
         src_err = 2'b00;
         step();
         faults++;
         exp = (faults > 255) ? 8'd255 : 8'(faults);
         tests++;
         if (err_cnt !== exp) begin
            fails++;
            $display("FAIL sat f=%0d got %0d want %0d", f, err_cnt, exp);
         end
      end
   endtask

   task automatic test_last_warmup_error();
      for (int k = 0; k < 64 && state !== 3'd2; k++) step();
      for (int i = 0; i < WARMUP_OUTS - 1; i++) begin
         src_valid = 1'b1;
         src_data = OUT_W'($urandom);
         step();
      end
      src_err = 2'b11;
      step();
      src_valid = 1'b0;
      src_err = 2'b00;
      tests++;
      if (state !== 3'd4 || data_valid !== 1'b0 || err_cnt !== 8'd255) begin
         fails++;
         $display("FAIL last_warm_err got st=%0d dv=%b ec=%0d want 4 0 255",
                  state, data_valid, err_cnt);
      end
   endtask

   task automatic test_enable();
      bit bad = 1'b0;
      for (int k = 0; k < 64 && state !== 3'd2; k++) step();
      repeat (3) step();
      enable = 1'b0;
      step();
      tests++;
      if (state !== 3'd0 || fir_rstn !== 1'b0 || sink_valid !== 1'b0 ||
          data_valid !== 1'b0) begin
         fails++;
         $display("FAIL disable got st=%0d fr=%b sv=%b dv=%b want 0 0 0 0",
                  state, fir_rstn, sink_valid, data_valid);
      end
      tests++;
      if (err_cnt !== 8'd255 || data !== last_data) begin
         fails++;
         $display("FAIL disable_keep got ec=%0d d=%0h want 255 %0h",
                  err_cnt, data, last_data);
      end
      for (int i = 0; i < 20; i++) begin
         src_valid = ~src_valid;
         src_data = OUT_W'($urandom);
         step();
         if (state !== 3'd0 || sink_valid || data_valid || fir_rstn) bad = 1'b1;
      end
      src_valid = 1'b0;
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL disable_idle got activity want none");
      end
   endtask

   task automatic test_reset_run();
      logic [OUT_W-1:0] drv;
      enable = 1'b1;
      rate_div = 16'd2;
      for (int k = 0; k < 64 && state !== 3'd2; k++) step();
      for (int i = 0; i < WARMUP_OUTS; i++) begin
         src_valid = 1'b1;
         src_data = OUT_W'($urandom);
         step();
      end
      drv = OUT_W'($urandom);
      src_data = drv;
      step();
      tests++;
      if (state !== 3'd3 || data_valid !== 1'b1 || data !== drv) begin
         fails++;
         $display("FAIL run_fwd got st=%0d dv=%b d=%0h want 3 1 %0h",
                  state, data_valid, data, drv);
      end
      rstn = 1'b0;
      src_data = OUT_W'($urandom);
      step();
      rstn = 1'b1;
      enable = 1'b0;
      src_valid = 1'b0;
      tests++;
      if (state !== 3'd0 || data !== '0 || err_cnt !== 8'd0 ||
          {fir_rstn, sink_valid, data_valid} !== 3'b000) begin
         fails++;
         $display("FAIL run_reset got st=%0d d=%0h ec=%0d flags=%b want 0",
                  state, data, err_cnt, {fir_rstn, sink_valid, data_valid});
      end
   endtask

   initial begin
      rstn = 1'b0;
      enable = 1'b0;
      rate_div = '0;
      adc = '0;
      src_valid = 1'b0;
      src_data = '0;
      src_err = 2'b00;
      test_reset();
      test_pacing();
      test_rate_change();
      test_warmup();
      test_error();
      test_timeout();
      test_saturation();
      test_last_warmup_error();
      test_enable();
      test_reset_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
